// File: rtl/cpu_mm_write_xbar_4x4.sv
// Write-direction 4x4 crossbar: four CPU write ports to four memory modules,
// with one round-robin arbiter and one-entry output register per memory module.
module cpu_mm_write_xbar_4x4 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid_0_i,
  input  logic [1:0]        cpu_dest_0_i,
  input  logic [DATA_W-1:0] cpu_data_0_i,
  output logic              cpu_ready_0_o,
  input  logic              cpu_valid_1_i,
  input  logic [1:0]        cpu_dest_1_i,
  input  logic [DATA_W-1:0] cpu_data_1_i,
  output logic              cpu_ready_1_o,
  input  logic              cpu_valid_2_i,
  input  logic [1:0]        cpu_dest_2_i,
  input  logic [DATA_W-1:0] cpu_data_2_i,
  output logic              cpu_ready_2_o,
  input  logic              cpu_valid_3_i,
  input  logic [1:0]        cpu_dest_3_i,
  input  logic [DATA_W-1:0] cpu_data_3_i,
  output logic              cpu_ready_3_o,
  output logic              mm_valid_0_o,
  output logic [DATA_W-1:0] mm_data_0_o,
  output logic [1:0]        mm_src_0_o,
  input  logic              mm_ready_0_i,
  output logic              mm_valid_1_o,
  output logic [DATA_W-1:0] mm_data_1_o,
  output logic [1:0]        mm_src_1_o,
  input  logic              mm_ready_1_i,
  output logic              mm_valid_2_o,
  output logic [DATA_W-1:0] mm_data_2_o,
  output logic [1:0]        mm_src_2_o,
  input  logic              mm_ready_2_i,
  output logic              mm_valid_3_o,
  output logic [DATA_W-1:0] mm_data_3_o,
  output logic [1:0]        mm_src_3_o,
  input  logic              mm_ready_3_i
);

  logic [3:0]        cpu_valid;
  logic [1:0]        cpu_dest [4];
  logic [DATA_W-1:0] cpu_data [4];
  logic [3:0]        cpu_ready;
  logic [3:0]        mm_ready;

  logic [3:0]        mm_valid_q;
  logic [DATA_W-1:0] mm_data_q [4];
  logic [1:0]        mm_src_q  [4];
  logic [1:0]        ptr_q     [4];

  logic [3:0]        req   [4];
  logic [3:0]        grant [4];
  logic [1:0]        win   [4];
  logic [3:0]        slot_free;
  logic [3:0]        load;

  assign cpu_valid = {cpu_valid_3_i, cpu_valid_2_i, cpu_valid_1_i, cpu_valid_0_i};
  assign cpu_dest[0] = cpu_dest_0_i;
  assign cpu_dest[1] = cpu_dest_1_i;
  assign cpu_dest[2] = cpu_dest_2_i;
  assign cpu_dest[3] = cpu_dest_3_i;
  assign cpu_data[0] = cpu_data_0_i;
  assign cpu_data[1] = cpu_data_1_i;
  assign cpu_data[2] = cpu_data_2_i;
  assign cpu_data[3] = cpu_data_3_i;
  assign mm_ready  = {mm_ready_3_i, mm_ready_2_i, mm_ready_1_i, mm_ready_0_i};

  // Scan downward so the requester closest to ptr is written last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    for (int m = 0; m < 4; m++) begin
      req[m] = '0;
      for (int n = 0; n < 4; n++) begin
        req[m][n] = cpu_valid[n] && (cpu_dest[n] == 2'(m));
      end
      win[m]       = rr_pick(req[m], ptr_q[m]);
      grant[m]     = (|req[m]) ? 4'(4'b0001 << win[m]) : 4'b0000;
      slot_free[m] = !mm_valid_q[m] || mm_ready[m];
      load[m]      = slot_free[m] && (|req[m]);
    end
  end

  // Gated with rst_n so no CPU sees an acceptance while the block is held in reset.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      cpu_ready[n] = rst_n && slot_free[cpu_dest[n]] && grant[cpu_dest[n]][n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 4; m++) begin
        mm_valid_q[m] <= 1'b0;
        mm_data_q[m]  <= '0;
        mm_src_q[m]   <= 2'd0;
        ptr_q[m]      <= 2'd0;
      end
    end else begin
      for (int m = 0; m < 4; m++) begin
        if (load[m]) begin
          mm_valid_q[m] <= 1'b1;
          mm_data_q[m]  <= cpu_data[win[m]];
          mm_src_q[m]   <= win[m];
          ptr_q[m]      <= win[m] + 2'd1;
        end else if (mm_ready[m]) begin
          mm_valid_q[m] <= 1'b0;
        end
      end
    end
  end

  assign cpu_ready_0_o = cpu_ready[0];
  assign cpu_ready_1_o = cpu_ready[1];
  assign cpu_ready_2_o = cpu_ready[2];
  assign cpu_ready_3_o = cpu_ready[3];

  assign mm_valid_0_o = mm_valid_q[0];
  assign mm_valid_1_o = mm_valid_q[1];
  assign mm_valid_2_o = mm_valid_q[2];
  assign mm_valid_3_o = mm_valid_q[3];
  assign mm_data_0_o  = mm_data_q[0];
  assign mm_data_1_o  = mm_data_q[1];
  assign mm_data_2_o  = mm_data_q[2];
  assign mm_data_3_o  = mm_data_q[3];
  assign mm_src_0_o   = mm_src_q[0];
  assign mm_src_1_o   = mm_src_q[1];
  assign mm_src_2_o   = mm_src_q[2];
  assign mm_src_3_o   = mm_src_q[3];

endmodule

// File: tb/tb_cpu_mm_write_xbar_4x4.sv
// Directed bench for the 4x4 write crossbar: reset, parallel routing,
// round-robin, backpressure, pointer hold and asynchronous mid-run reset.
module tb_cpu_mm_write_xbar_4x4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cpu_valid;
  logic [1:0] cpu_dest [4];
  logic [7:0] cpu_data [4];
  logic [3:0] mm_ready;

  logic       cpu_ready_0, cpu_ready_1, cpu_ready_2, cpu_ready_3;
  logic       mm_valid_0, mm_valid_1, mm_valid_2, mm_valid_3;
  logic [7:0] mm_data_0, mm_data_1, mm_data_2, mm_data_3;
  logic [1:0] mm_src_0, mm_src_1, mm_src_2, mm_src_3;

  logic [3:0] cpu_ready_v;
  logic [3:0] mm_valid_v;
  logic [7:0] mm_data [4];
  logic [1:0] mm_src  [4];

  int tests = 0;
  int fails = 0;

  assign cpu_ready_v = {cpu_ready_3, cpu_ready_2, cpu_ready_1, cpu_ready_0};
  assign mm_valid_v  = {mm_valid_3, mm_valid_2, mm_valid_1, mm_valid_0};
  assign mm_data[0] = mm_data_0;
  assign mm_data[1] = mm_data_1;
  assign mm_data[2] = mm_data_2;
  assign mm_data[3] = mm_data_3;
  assign mm_src[0]  = mm_src_0;
  assign mm_src[1]  = mm_src_1;
  assign mm_src[2]  = mm_src_2;
  assign mm_src[3]  = mm_src_3;

  always #5 clk = ~clk;

  cpu_mm_write_xbar_4x4 #(.DATA_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_valid_0_i (cpu_valid[0]), .cpu_dest_0_i (cpu_dest[0]), .cpu_data_0_i (cpu_data[0]), .cpu_ready_0_o (cpu_ready_0),
    .cpu_valid_1_i (cpu_valid[1]), .cpu_dest_1_i (cpu_dest[1]), .cpu_data_1_i (cpu_data[1]), .cpu_ready_1_o (cpu_ready_1),
    .cpu_valid_2_i (cpu_valid[2]), .cpu_dest_2_i (cpu_dest[2]), .cpu_data_2_i (cpu_data[2]), .cpu_ready_2_o (cpu_ready_2),
    .cpu_valid_3_i (cpu_valid[3]), .cpu_dest_3_i (cpu_dest[3]), .cpu_data_3_i (cpu_data[3]), .cpu_ready_3_o (cpu_ready_3),
    .mm_valid_0_o  (mm_valid_0), .mm_data_0_o (mm_data_0), .mm_src_0_o (mm_src_0), .mm_ready_0_i (mm_ready[0]),
    .mm_valid_1_o  (mm_valid_1), .mm_data_1_o (mm_data_1), .mm_src_1_o (mm_src_1), .mm_ready_1_i (mm_ready[1]),
    .mm_valid_2_o  (mm_valid_2), .mm_data_2_o (mm_data_2), .mm_src_2_o (mm_src_2), .mm_ready_2_i (mm_ready[2]),
    .mm_valid_3_o  (mm_valid_3), .mm_data_3_o (mm_data_3), .mm_src_3_o (mm_src_3), .mm_ready_3_i (mm_ready[3])
  );

  task automatic clear_inputs();
    cpu_valid = 4'b0000;
    mm_ready  = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      cpu_dest[n] = 2'd0;
      cpu_data[n] = 8'h00;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mm_ready = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      cpu_valid[n] = 1'b1;
      cpu_dest[n]  = 2'(n);
      cpu_data[n]  = 8'(8'hE0 + n);
    end
    repeat (2) @(posedge clk);
    #1;
    tests++; if (mm_valid_v !== 4'b0000) begin fails++; $display("FAIL rst_mm_valid: got %b want 0000", mm_valid_v); end
    tests++; if (cpu_ready_v !== 4'b0000) begin fails++; $display("FAIL rst_cpu_ready: got %b want 0000", cpu_ready_v); end
    for (int m = 0; m < 4; m++) begin
      tests++; if (mm_data[m] !== 8'h00 || mm_src[m] !== 2'd0) begin
        fails++; $display("FAIL rst_mm%0d_data_src: got %h/%0d want 00/0", m, mm_data[m], mm_src[m]);
      end
    end
    // After release all four target MM0; ptr_0=0 so CPU0 wins.
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) cpu_dest[n] = 2'd0;
    #1;
    tests++; if (cpu_ready_v !== 4'b0001) begin fails++; $display("FAIL rst_first_grant: got %b want 0001", cpu_ready_v); end
    @(posedge clk); #1;
    tests++; if (mm_valid_0 !== 1'b1 || mm_src_0 !== 2'd0 || mm_data_0 !== 8'hE0) begin
      fails++; $display("FAIL rst_first_beat: got v%b %h/%0d want v1 e0/0", mm_valid_0, mm_data_0, mm_src_0);
    end
  endtask

  task automatic test_parallel();
    logic [7:0] exp_d [4];
    apply_reset();
    exp_d[0] = 8'hD3; exp_d[1] = 8'hC2; exp_d[2] = 8'hB1; exp_d[3] = 8'hA0;
    @(negedge clk);
    mm_ready = 4'b1111;
    cpu_valid = 4'b1111;
    cpu_dest[0] = 2'd3; cpu_data[0] = 8'hA0;
    cpu_dest[1] = 2'd2; cpu_data[1] = 8'hB1;
    cpu_dest[2] = 2'd1; cpu_data[2] = 8'hC2;
    cpu_dest[3] = 2'd0; cpu_data[3] = 8'hD3;
    #1;
    tests++; if (cpu_ready_v !== 4'b1111) begin fails++; $display("FAIL par_ready: got %b want 1111", cpu_ready_v); end
    @(posedge clk); #1;
    tests++; if (mm_valid_v !== 4'b1111) begin fails++; $display("FAIL par_valid: got %b want 1111", mm_valid_v); end
    for (int m = 0; m < 4; m++) begin
      tests++; if (mm_data[m] !== exp_d[m] || mm_src[m] !== 2'(3 - m)) begin
        fails++; $display("FAIL par_mm%0d: got %h/%0d want %h/%0d", m, mm_data[m], mm_src[m], exp_d[m], 3 - m);
      end
    end
    @(negedge clk);
    cpu_valid = 4'b0000;
    @(posedge clk); #1;
    tests++; if (mm_valid_v !== 4'b0000) begin fails++; $display("FAIL par_drain: got %b want 0000", mm_valid_v); end
  endtask

  task automatic test_round_robin();
    int exp;
    apply_reset();
    @(negedge clk);
    mm_ready = 4'b1111;
    cpu_valid = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      cpu_dest[n] = 2'd1;
      cpu_data[n] = 8'(8'h10 + n);
    end
    for (int i = 0; i < 5; i++) begin
      exp = i % 4;
      #1;
      tests++; if (cpu_ready_v !== 4'(1 << exp)) begin
        fails++; $display("FAIL rr_ready_%0d: got %b want %b", i, cpu_ready_v, 4'(1 << exp));
      end
      @(posedge clk); #1;
      tests++; if (mm_valid_1 !== 1'b1 || mm_src_1 !== 2'(exp) || mm_data_1 !== 8'(8'h10 + exp)) begin
        fails++; $display("FAIL rr_beat_%0d: got v%b %h/%0d want v1 %h/%0d", i, mm_valid_1, mm_data_1, mm_src_1, 8'(8'h10 + exp), exp);
      end
      @(negedge clk);
    end
    cpu_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    apply_reset();
    @(negedge clk);
    cpu_valid[2] = 1'b1; cpu_dest[2] = 2'd0; cpu_data[2] = 8'h5A;
    #1;
    tests++; if (cpu_ready_v !== 4'b0100) begin fails++; $display("FAIL bp_first_ready: got %b want 0100", cpu_ready_v); end
    @(negedge clk);
    cpu_valid[2] = 1'b0;
    cpu_valid[1] = 1'b1; cpu_dest[1] = 2'd0; cpu_data[1] = 8'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (cpu_ready_1 !== 1'b0 || mm_valid_0 !== 1'b1 || mm_data_0 !== 8'h5A || mm_src_0 !== 2'd2) begin
        fails++; $display("FAIL bp_stall_%0d: got rdy%b v%b %h/%0d want rdy0 v1 5a/2", c, cpu_ready_1, mm_valid_0, mm_data_0, mm_src_0);
      end
      @(negedge clk);
    end
    mm_ready[0] = 1'b1;
    #1;
    tests++; if (cpu_ready_1 !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", cpu_ready_1); end
    @(posedge clk); #1;
    tests++; if (mm_valid_0 !== 1'b1 || mm_data_0 !== 8'h77 || mm_src_0 !== 2'd1) begin
      fails++; $display("FAIL bp_replace: got v%b %h/%0d want v1 77/1", mm_valid_0, mm_data_0, mm_src_0);
    end
    @(negedge clk);
    cpu_valid[1] = 1'b0;
    @(posedge clk); #1;
    tests++; if (mm_valid_0 !== 1'b0 || mm_data_0 !== 8'h77) begin
      fails++; $display("FAIL bp_drain: got v%b %h want v0 77", mm_valid_0, mm_data_0);
    end
  endtask

  task automatic test_pointer_hold();
    apply_reset();
    @(negedge clk);
    cpu_valid[0] = 1'b1; cpu_dest[0] = 2'd2; cpu_data[0] = 8'h20;
    @(negedge clk);
    // ptr_2 is now 1 and the slot is stalled; both CPU0 and CPU3 contend.
    cpu_data[0] = 8'h30;
    cpu_valid[3] = 1'b1; cpu_dest[3] = 2'd2; cpu_data[3] = 8'h33;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (cpu_ready_v !== 4'b0000 || mm_data_2 !== 8'h20) begin
        fails++; $display("FAIL ph_stall_%0d: got rdy%b %h want rdy0000 20", c, cpu_ready_v, mm_data_2);
      end
      @(negedge clk);
    end
    mm_ready[2] = 1'b1;
    #1;
    tests++; if (cpu_ready_v !== 4'b1000) begin fails++; $display("FAIL ph_cpu3_first: got %b want 1000", cpu_ready_v); end
    @(posedge clk); #1;
    tests++; if (mm_data_2 !== 8'h33 || mm_src_2 !== 2'd3) begin
      fails++; $display("FAIL ph_beat3: got %h/%0d want 33/3", mm_data_2, mm_src_2);
    end
    @(negedge clk);
    cpu_valid[3] = 1'b0;
    #1;
    tests++; if (cpu_ready_v !== 4'b0001) begin fails++; $display("FAIL ph_cpu0_next: got %b want 0001", cpu_ready_v); end
    @(posedge clk); #1;
    tests++; if (mm_valid_2 !== 1'b1 || mm_data_2 !== 8'h30 || mm_src_2 !== 2'd0) begin
      fails++; $display("FAIL ph_beat0: got v%b %h/%0d want v1 30/0", mm_valid_2, mm_data_2, mm_src_2);
    end
    @(negedge clk);
    cpu_valid = 4'b0000;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    @(negedge clk);
    cpu_valid = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      cpu_dest[n] = 2'(3 - n);
      cpu_data[n] = 8'(8'h40 + n);
    end
    @(posedge clk); #1;
    tests++; if (mm_valid_v !== 4'b1111) begin fails++; $display("FAIL mr_loaded: got %b want 1111", mm_valid_v); end
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if (mm_valid_v !== 4'b0000) begin fails++; $display("FAIL mr_valid_drop: got %b want 0000", mm_valid_v); end
    tests++; if (cpu_ready_v !== 4'b0000) begin fails++; $display("FAIL mr_ready_low: got %b want 0000", cpu_ready_v); end
    // ptr_3 had advanced to 1; after reset CPU0 must win MM3 again.
    @(negedge clk);
    rst_n = 1'b1;
    mm_ready = 4'b1111;
    for (int n = 0; n < 4; n++) cpu_dest[n] = 2'd3;
    #1;
    tests++; if (cpu_ready_v !== 4'b0001) begin fails++; $display("FAIL mr_ptr_reset: got %b want 0001", cpu_ready_v); end
    @(posedge clk); #1;
    tests++; if (mm_src_3 !== 2'd0 || mm_data_3 !== 8'h40) begin
      fails++; $display("FAIL mr_first_beat: got %h/%0d want 40/0", mm_data_3, mm_src_3);
    end
    @(negedge clk);
    cpu_valid = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_parallel();
    test_round_robin();
    test_backpressure();
    test_pointer_hold();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
